pc_fetch_unit: RTL

Program-counter and instruction-fetch sequencer for the MIPS core. It consumes the word-aligned branch offset produced by the shift-left-2 stage and forms the branch target as PC+4 plus that offset, along with the jump and jump-register targets. It holds the PC register and runs a request/ready handshake with instruction memory. It presents one fetched instruction at a time to decode and advances only when decode is not stalled.

---
 rtl/mips_pkg.sv | 15 +
 rtl/next_pc_sel.sv | 39 +++
 rtl/pc_fetch_unit.sv | 103 ++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS fetch front end.
package mips_pkg;

   localparam int WORD_W = 32;
   localparam int JIDX_W = 26;

   localparam logic [WORD_W-1:0] NOP = 32'h0000_0000;

   typedef enum logic [1:0] {
      BOOT,
      REQ,
      VALID
   } fetch_state_e;

endpackage

// File: rtl/next_pc_sel.sv
// Branch, jump and jump-register target formation with the redirect priority mux.
module next_pc_sel
   import mips_pkg::*;
(
   input  logic [WORD_W-1:0] pc_plus4,
   input  logic [WORD_W-1:0] branch_offset_sl2,
   input  logic [JIDX_W-1:0] jump_index,
   input  logic [WORD_W-1:0] jump_reg_addr,
   input  logic              branch_taken,
   input  logic              jump,
   input  logic              jump_reg,
   output logic [WORD_W-1:0] next_pc,
   output logic              misalign
);

   logic [WORD_W-1:0] branch_target;
   logic [WORD_W-1:0] jump_target;
   logic [WORD_W-1:0] jr_target;

   // Branch overflow wraps silently; the PC is a plain 32-bit modulo counter.
   assign branch_target = pc_plus4 + branch_offset_sl2;
   assign jump_target   = {pc_plus4[WORD_W-1:WORD_W-4], jump_index, 2'b00};
   assign jr_target     = {jump_reg_addr[WORD_W-1:2], 2'b00};

   always_comb begin
      // NOTE: every output gets a default first, so no path can infer a latch.
      next_pc  = pc_plus4;
      misalign = 1'b0;
      if (jump_reg) begin
         next_pc  = jr_target;
         misalign = |jump_reg_addr[1:0];
      end else if (jump) begin
         next_pc = jump_target;
      end else if (branch_taken) begin
         next_pc = branch_target;
      end
   end

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register and fetch sequencer: request/ready handshake with instruction
// memory, one registered instruction presented to decode at a time.
module pc_fetch_unit
   import mips_pkg::*;
#(
   parameter logic [WORD_W-1:0] RESET_VECTOR = 32'h0000_0000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [WORD_W-1:0] branch_offset_sl2,
   input  logic              branch_taken,
   input  logic              jump,
   input  logic [JIDX_W-1:0] jump_index,
   input  logic              jump_reg,
   input  logic [WORD_W-1:0] jump_reg_addr,
   input  logic              stall,
   output logic              imem_req,
   output logic [WORD_W-1:0] imem_addr,
   input  logic              imem_ready,
   input  logic [WORD_W-1:0] imem_rdata,
   output logic              instr_valid,
   output logic [WORD_W-1:0] instr,
   output logic [WORD_W-1:0] pc,
   output logic [WORD_W-1:0] pc_plus4,
   output logic              addr_err
);

   fetch_state_e      state_q, state_d;
   logic [WORD_W-1:0] pc_q, pc_d;
   logic [WORD_W-1:0] instr_q, instr_d;
   logic              instr_valid_q, instr_valid_d;
   logic              addr_err_q, addr_err_d;

   logic [WORD_W-1:0] next_pc;
   logic              misalign;

   assign pc_plus4 = pc_q + 32'd4;

   next_pc_sel u_next_pc_sel (
      .pc_plus4          (pc_plus4),
      .branch_offset_sl2 (branch_offset_sl2),
      .jump_index        (jump_index),
      .jump_reg_addr     (jump_reg_addr),
      .branch_taken      (branch_taken),
      .jump              (jump),
      .jump_reg          (jump_reg),
      .next_pc           (next_pc),
      .misalign          (misalign)
   );

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      instr_d       = instr_q;
      instr_valid_d = instr_valid_q;
      addr_err_d    = 1'b0;
      unique case (state_q)
         BOOT: state_d = REQ;
         REQ: begin
            if (imem_ready) begin
               instr_d       = imem_rdata;
               instr_valid_d = 1'b1;
               state_d       = VALID;
            end
         end
         VALID: begin
            // Redirects are only looked at on the cycle decode accepts the instruction.
            if (!stall) begin
               pc_d          = next_pc;
               instr_valid_d = 1'b0;
               addr_err_d    = misalign;
               state_d       = REQ;
            end
         end
         default: state_d = BOOT;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so all flops update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= BOOT;
         pc_q          <= RESET_VECTOR;
         instr_q       <= NOP;
         instr_valid_q <= 1'b0;
         addr_err_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         instr_q       <= instr_d;
         instr_valid_q <= instr_valid_d;
         addr_err_q    <= addr_err_d;
      end
   end

   assign imem_req    = (state_q == REQ);
   assign imem_addr   = pc_q;
   assign pc          = pc_q;
   assign instr       = instr_q;
   assign instr_valid = instr_valid_q;
   assign addr_err    = addr_err_q;

endmodule
